// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths and state encoding for the i-cache refill controller
package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int BLOCK_W        = 128;
    localparam int OFFSET_W       = 4;
    localparam int INDEX_W        = 3;
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_ADDR_W    = ADDR_W - OFFSET_W;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_REQ   = S_REQ,
        ST_DRAIN = S_DRAIN,
        ST_FILL  = S_FILL,
        ST_ERROR = S_ERROR
    } refill_state_t;

endpackage

// File: rtl/refill_watchdog.sv
// rtl/refill_watchdog.sv - cycle counter bounding how long a refill may wait on memory
//
// Ports:
//   clock    - posedge clock
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear (wins over enable)
//   enable   - count this cycle
//   terminal - count has reached LIMIT-1: the current enabled cycle is the LIMIT-th
module refill_watchdog #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == W'(LIMIT - 1));

endmodule

// File: rtl/icache_refill_controller.sv
// rtl/icache_refill_controller.sv - fetches one 128-bit line per i-cache miss from byte-serial memory
//
// Ports:
//   clock, reset  - posedge clock, asynchronous active-low reset
//   miss_req      - cache miss, sampled only in IDLE
//   miss_addr     - miss byte address (bits [1:0] unused)
//   stall         - CPU stall (combinational)
//   fill_valid    - one-cycle pulse: write fill_data at fill_index/fill_tag
//   fill_index    - set index of the refilled line
//   fill_tag      - tag of the refilled line
//   fill_data     - refilled line, byte k at [8k+7:8k]
//   fill_word     - 32-bit critical word selected by miss_addr[3:2]
//   mem_error     - sticky watchdog timeout flag
//   mem_read      - read request to instruction memory
//   mem_address   - line address, stable from REQ through FILL
//   mem_readdata  - line from memory
//   mem_busywait  - memory busy; low while mem_read means the last byte lands this edge
module icache_refill_controller
    import icache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   miss_req,
    input  logic [ADDR_W-1:0]      miss_addr,
    output logic                   stall,
    output logic                   fill_valid,
    output logic [INDEX_W-1:0]     fill_index,
    output logic [TAG_W-1:0]       fill_tag,
    output logic [BLOCK_W-1:0]     fill_data,
    output logic [31:0]            fill_word,
    output logic                   mem_error,
    output logic                   mem_read,
    output logic [LINE_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]     mem_readdata,
    input  logic                   mem_busywait
);

    refill_state_t state_q;
    refill_state_t state_d;
    logic [1:0]    word_off_q;
    logic          wd_enable;
    logic          wd_terminal;
    logic          miss_accept;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[1:0];

    assign miss_accept = (state_q == ST_IDLE) && miss_req;
    assign wd_enable   = (state_q == ST_REQ) && mem_busywait;
    assign stall       = miss_accept || (state_q != ST_IDLE);

    // Counts only while REQ is stalled by memory; any other cycle resets it.
    refill_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (WD_W)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (!wd_enable),
        .enable   (wd_enable),
        .terminal (wd_terminal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (miss_req) state_d = ST_REQ;
            ST_REQ: begin
                if (!mem_busywait) begin
                    state_d = ST_DRAIN;
                end else if (wd_terminal) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DRAIN: state_d = ST_FILL;
            ST_FILL:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_read    <= 1'b0;
            mem_error   <= 1'b0;
            mem_address <= '0;
            word_off_q  <= '0;
            fill_valid  <= 1'b0;
            fill_index  <= '0;
            fill_tag    <= '0;
            fill_data   <= '0;
            fill_word   <= '0;
        end else begin
            mem_read   <= (state_d == ST_REQ);
            mem_error  <= mem_error || (state_d == ST_ERROR);
            fill_valid <= (state_q == ST_DRAIN);
            if (miss_accept) begin
                mem_address <= miss_addr[ADDR_W-1:OFFSET_W];
                word_off_q  <= miss_addr[3:2];
            end
            // The last byte was written on the edge entering DRAIN, so the
            // line is complete on the edge leaving it.
            if (state_q == ST_DRAIN) begin
                fill_data  <= mem_readdata;
                fill_word  <= mem_readdata[{word_off_q, 5'b0} +: 32];
                fill_index <= mem_address[INDEX_W-1:0];
                fill_tag   <= mem_address[LINE_ADDR_W-1:INDEX_W];
            end
        end
    end

endmodule
